// File: rtl/imem_responder.sv
// Instruction-memory responder: a 16-bit word store written by a program loader and
// read by a CPU through a request/response handshake with fixed response latency.
module imem_responder #(
    parameter int          DEPTH    = 128,
    parameter int          LATENCY  = 2,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [7:0]  fetch_addr,
    output logic        fetch_ready,
    output logic        fetch_valid,
    output logic [15:0] fetch_data,
    output logic        fetch_err,
    input  logic        fetch_ack,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [15:0] load_data,
    output logic [15:0] fetch_count
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_W  = 9'(DEPTH);
    localparam logic [2:0] LAT_LOAD = 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic [2:0]  lat_cnt_r;
    logic [15:0] mem_r [DEPTH];

    logic        fetch_in_range_s;
    logic        load_in_range_s;
    logic [15:0] rd_word_s;
    logic        accept_s;

    // A pending load blocks acceptance so the loader always wins the IDLE cycle.
    assign fetch_ready = (state_r == ST_IDLE) && !load_en;
    assign accept_s    = fetch_req && fetch_ready;

    // Address range decode and read mux; out-of-range fetches return the NOP word.
    always_comb begin
        fetch_in_range_s = ({1'b0, fetch_addr} < DEPTH_W);
        load_in_range_s  = ({1'b0, load_addr} < DEPTH_W);
        if (fetch_in_range_s) begin
            rd_word_s = mem_r[fetch_addr[AW-1:0]];
        end else begin
            rd_word_s = NOP_WORD;
        end
    end

    // Loader write port; memory survives reset but writes are suppressed while it is held.
    always_ff @(posedge clk) begin
        if (!rst && load_en && load_in_range_s) begin
            mem_r[load_addr[AW-1:0]] <= load_data;
        end
    end

    // Handshake FSM; the response is snapshotted at acceptance so later loads cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            lat_cnt_r   <= 3'd0;
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_data  <= 16'h0000;
            fetch_count <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        fetch_data <= rd_word_s;
                        fetch_err  <= !fetch_in_range_s;
                        if (LATENCY == 1) begin
                            state_r     <= ST_RESP;
                            fetch_valid <= 1'b1;
                        end else begin
                            state_r   <= ST_WAIT;
                            lat_cnt_r <= LAT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_r <= 3'd1) begin
                        state_r     <= ST_RESP;
                        fetch_valid <= 1'b1;
                        lat_cnt_r   <= 3'd0;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (fetch_ack) begin
                        state_r     <= ST_IDLE;
                        fetch_valid <= 1'b0;
                        if (fetch_count != 16'hFFFF) begin
                            fetch_count <= fetch_count + 16'd1;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    fetch_valid <= 1'b0;
                    lat_cnt_r   <= 3'd0;
                end
            endcase
        end
    end

endmodule
